// File: rtl/lane_align_ctrl_if.sv
// Handshake/status bundle between the lane gearboxes, the px_ready source and lane_align_ctrl.
interface lane_align_ctrl_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic                   start;
  logic [7*NUM_LANES-1:0] lane_data;
  logic [NUM_LANES-1:0]   lane_slip;
  logic [NUM_LANES-1:0]   lane_aligned;
  logic [NUM_LANES-1:0]   lane_error;
  logic [3:0]             cur_lane;
  logic                   align_busy;
  logic                   align_done;

  modport master (
    output start, lane_data,
    input  lane_slip, lane_aligned, lane_error, cur_lane, align_busy, align_done
  );

  modport slave (
    input  start, lane_data,
    output lane_slip, lane_aligned, lane_error, cur_lane, align_busy, align_done
  );
endinterface

// File: rtl/lane_align_ctrl.sv
// Word-alignment sequencer: one shared comparator walks the lanes, slipping each gearbox until the
// training word repeats. LANE_ALIGN_RETRY_EN adds a second pass over lanes that failed.
module lane_align_ctrl #(
  parameter int unsigned NUM_LANES     = 4,
  parameter logic [6:0]  TRAIN_PATTERN = 7'b110_0011,
  parameter int unsigned MATCH_COUNT   = 8,
  parameter int unsigned SETTLE_CYCLES = 6
) (
  input logic              px_clk,
  input logic              px_reset,
  lane_align_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    StIdle, StSelect, StCheck, StSlip, StSettle, StNext, StDone
  } state_e;

  localparam logic [3:0] LastLane    = 4'(NUM_LANES - 1);
  localparam logic [3:0] MatchTarget = 4'(MATCH_COUNT);
  localparam logic [3:0] SettleLoad  = 4'(SETTLE_CYCLES);

  state_e               state_q, state_d;
  logic [3:0]           cur_lane_q, cur_lane_d;
  logic [2:0]           slip_cnt_q, slip_cnt_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic [3:0]           settle_cnt_q, settle_cnt_d;
  logic [NUM_LANES-1:0] aligned_q, aligned_d;
  logic [NUM_LANES-1:0] error_q, error_d;
  logic [6:0]           sel_word_q, sel_word_d;
  logic [NUM_LANES-1:0] lane_oh;
  logic [3:0]           match_inc;
  logic                 is_match;

  // Lane decode and comparator input mux share one walk over the lanes.
  always_comb begin
    lane_oh    = '0;
    sel_word_d = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (cur_lane_q == 4'(i)) begin
        lane_oh[i] = 1'b1;
        sel_word_d = bus.lane_data[7*i +: 7];
      end
    end
  end

  assign is_match  = (sel_word_q == TRAIN_PATTERN);
  assign match_inc = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;

`ifdef LANE_ALIGN_RETRY_EN
  logic       pass_q, pass_d;
  logic       retry_found;
  logic [3:0] retry_lane;

  // Lowest errored lane still ahead: any lane on the first pass, above cur_lane on the retry pass.
  always_comb begin
    retry_found = 1'b0;
    retry_lane  = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (error_q[i] && (!pass_q || (i > int'(cur_lane_q)))) begin
        retry_found = 1'b1;
        retry_lane  = 4'(i);
      end
    end
  end

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end
`endif

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      state_q      <= StIdle;
      cur_lane_q   <= '0;
      slip_cnt_q   <= '0;
      match_cnt_q  <= '0;
      settle_cnt_q <= '0;
      aligned_q    <= '0;
      error_q      <= '0;
      sel_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_lane_q   <= cur_lane_d;
      slip_cnt_q   <= slip_cnt_d;
      match_cnt_q  <= match_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      aligned_q    <= aligned_d;
      error_q      <= error_d;
      sel_word_q   <= sel_word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_lane_d   = cur_lane_q;
    slip_cnt_d   = slip_cnt_q;
    match_cnt_d  = match_cnt_q;
    settle_cnt_d = settle_cnt_q;
    aligned_d    = aligned_q;
    error_d      = error_q;
`ifdef LANE_ALIGN_RETRY_EN
    pass_d       = pass_q;
`endif
    if (!bus.start) begin
      // Abort beats any decision taken this cycle.
      state_d     = StIdle;
      cur_lane_d  = '0;
      slip_cnt_d  = '0;
      match_cnt_d = '0;
      aligned_d   = '0;
      error_d     = '0;
`ifdef LANE_ALIGN_RETRY_EN
      pass_d      = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StSelect;
          cur_lane_d  = '0;
          slip_cnt_d  = '0;
          match_cnt_d = '0;
          aligned_d   = '0;
          error_d     = '0;
`ifdef LANE_ALIGN_RETRY_EN
          pass_d      = 1'b0;
`endif
        end
        StSelect: begin
          state_d = StCheck;
`ifdef LANE_ALIGN_RETRY_EN
          if (pass_q) error_d = error_q & ~lane_oh;
`endif
        end
        StCheck: begin
          if (is_match) begin
            match_cnt_d = match_inc;
            if (match_inc == MatchTarget) begin
              aligned_d = aligned_q | lane_oh;
              state_d   = StNext;
            end
          end else if (slip_cnt_q != 3'd7) begin
            match_cnt_d = '0;
            state_d     = StSlip;
          end else begin
            error_d = error_q | lane_oh;
            state_d = StNext;
          end
        end
        StSlip: begin
          slip_cnt_d   = slip_cnt_q + 3'd1;
          settle_cnt_d = SettleLoad;
          state_d      = StSettle;
        end
        StSettle: begin
          if (settle_cnt_q <= 4'd1) begin
            state_d = StCheck;
          end else begin
            settle_cnt_d = settle_cnt_q - 4'd1;
          end
        end
        StNext: begin
          slip_cnt_d  = '0;
          match_cnt_d = '0;
`ifdef LANE_ALIGN_RETRY_EN
          if (!pass_q && (cur_lane_q != LastLane)) begin
            cur_lane_d = cur_lane_q + 4'd1;
            state_d    = StSelect;
          end else if (retry_found) begin
            pass_d     = 1'b1;
            cur_lane_d = retry_lane;
            state_d    = StSelect;
          end else begin
            state_d = StDone;
          end
`else
          if (cur_lane_q == LastLane) begin
            state_d = StDone;
          end else begin
            cur_lane_d = cur_lane_q + 4'd1;
            state_d    = StSelect;
          end
`endif
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.lane_slip    = (state_q == StSlip) ? lane_oh : '0;
    bus.lane_aligned = aligned_q;
    bus.lane_error   = error_q;
    bus.cur_lane     = cur_lane_q;
    bus.align_busy   = (state_q != StIdle) && (state_q != StDone);
    bus.align_done   = (state_q == StDone);
  end
endmodule

// File: tb/tb_lane_align_ctrl.sv
// Bench for lane_align_ctrl: rotating-gearbox lane models, outcome/latency predicted per lane.
module tb_lane_align_ctrl;
  localparam int         NL  = 4;
  localparam logic [6:0] PAT = 7'b110_0011;
  localparam int         MC  = 8;
  localparam int         SC  = 6;

  logic px_clk = 1'b0;
  logic px_reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Gearbox model: word is PAT rotated left by off; each slip lowers off by one (mod 7).
  int   off[NL];
  bit   zero_lane[NL];
  int   slip_seen[NL];
  int   last_slip[NL];

  int   exp_slips[NL];
  logic [NL-1:0] exp_al, exp_er;
  int   exp_t, exp_cur;

  lane_align_ctrl_if #(.NUM_LANES(NL)) bus ();

  lane_align_ctrl #(
    .NUM_LANES    (NL),
    .TRAIN_PATTERN(PAT),
    .MATCH_COUNT  (MC),
    .SETTLE_CYCLES(SC)
  ) dut (
    .px_clk  (px_clk),
    .px_reset(px_reset),
    .bus     (bus)
  );

  always #5 px_clk = ~px_clk;

  function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
    logic [6:0] r;
    r = w;
    for (int k = 0; k < n; k++) r = {r[5:0], r[6]};
    return r;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_gearbox
    assign bus.lane_data[7*g +: 7] = zero_lane[g] ? 7'h00 : rotl(PAT, off[g]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Slip monitor: applies slips to the gearbox model and polices pulse shape.
  initial forever begin
    @(negedge px_clk);
    cyc++;
    if (bus.lane_slip != '0) begin
      check("slip_onehot", $countones(bus.lane_slip), 1);
      for (int i = 0; i < NL; i++) begin
        if (bus.lane_slip[i]) begin
          if (last_slip[i] >= 0) check("slip_spacing", int'(cyc - last_slip[i] >= SC + 2), 1);
          last_slip[i] = cyc;
          slip_seen[i]++;
          off[i] = (off[i] + 6) % 7;
        end
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < NL; i++) begin
      slip_seen[i] = 0;
      last_slip[i] = -1;
    end
  endtask

  // Outcome per lane from the lane cost rules; retry replays each failed lane once more.
  task automatic predict();
    exp_t   = 0;
    exp_cur = NL - 1;
    for (int i = 0; i < NL; i++) begin
      if (zero_lane[i]) begin
        exp_slips[i] = 7;
        exp_al[i]    = 1'b0;
        exp_er[i]    = 1'b1;
        exp_t       += 1 + 7 * (SC + 2) + 1 + 1;
      end else begin
        exp_slips[i] = off[i];
        exp_al[i]    = 1'b1;
        exp_er[i]    = 1'b0;
        exp_t       += 1 + off[i] * (SC + 2) + MC + 1;
      end
    end
`ifdef LANE_ALIGN_RETRY_EN
    for (int i = 0; i < NL; i++) begin
      if (zero_lane[i]) begin
        exp_slips[i] += 7;
        exp_t        += 1 + 7 * (SC + 2) + 1 + 1;
        exp_cur       = i;
      end
    end
`endif
  endtask

  task automatic run_and_check(input string name);
    int got;
    predict();
    clear_counts();
    bus.start = 1'b1;
    got = -1;
    for (int k = 0; k < 3000 && got < 0; k++) begin
      @(negedge px_clk);
      if (k == 0) begin
        check({name, ".first_lane"}, bus.cur_lane, 0);
        check({name, ".busy"}, bus.align_busy, 1);
      end
      if (bus.align_done) got = k;
    end
    check({name, ".done_edge"}, got, exp_t);
    check({name, ".aligned"}, bus.lane_aligned, exp_al);
    check({name, ".error"}, bus.lane_error, exp_er);
    check({name, ".exclusive"}, bus.lane_aligned & bus.lane_error, 0);
    check({name, ".cur_lane"}, bus.cur_lane, exp_cur);
    check({name, ".idle_busy"}, bus.align_busy, 0);
    for (int i = 0; i < NL; i++) check($sformatf("%s.slips%0d", name, i), slip_seen[i], exp_slips[i]);
    @(negedge px_clk);
    bus.start = 1'b0;
    @(negedge px_clk);
    check({name, ".drop_done"}, bus.align_done, 0);
    check({name, ".drop_flags"}, {bus.lane_aligned, bus.lane_error}, 0);
  endtask

  task automatic set_lanes(input int o0, input int o1, input int o2, input int o3);
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    for (int i = 0; i < NL; i++) zero_lane[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".slip"}, bus.lane_slip, 0);
    check({name, ".aligned"}, bus.lane_aligned, 0);
    check({name, ".error"}, bus.lane_error, 0);
    check({name, ".cur_lane"}, bus.cur_lane, 0);
    check({name, ".busy"}, bus.align_busy, 0);
    check({name, ".done"}, bus.align_done, 0);
  endtask

  initial begin
    int waited;
    px_reset  = 1'b1;
    bus.start = 1'b0;
    set_lanes(0, 0, 0, 0);
    clear_counts();
    #1;
    check_reset_outputs("reset");
    @(negedge px_clk);
    @(negedge px_clk);
    px_reset = 1'b0;
    @(negedge px_clk);

    set_lanes(0, 0, 0, 0);
    run_and_check("all_aligned");

    set_lanes(0, 0, 3, 0);
    run_and_check("lane2_off3");

    set_lanes(0, 0, 0, 0);
    zero_lane[1] = 1'b1;
    run_and_check("lane1_zero");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NL; i++) begin
        off[i]       = $urandom_range(0, 6);
        zero_lane[i] = ($urandom_range(0, 4) == 0);
      end
      run_and_check($sformatf("rand%0d", r));
    end

    // Abort while lane 0 settles after its first slip.
    set_lanes(2, 0, 0, 0);
    clear_counts();
    bus.start = 1'b1;
    waited = 0;
    while (slip_seen[0] == 0 && waited < 100) begin
      @(negedge px_clk);
      waited++;
    end
    check("abort.slip_seen", slip_seen[0], 1);
    @(negedge px_clk);
    check("abort.in_settle", bus.align_busy, 1);
    bus.start = 1'b0;
    @(negedge px_clk);
    check_reset_outputs("abort");
    set_lanes(0, 0, 0, 0);
    run_and_check("restart");

    // Asynchronous reset while lane 1 is in CHECK.
    set_lanes(0, 0, 0, 0);
    bus.start = 1'b1;
    repeat (15) @(negedge px_clk);
    check("rst_mid.pre_aligned", bus.lane_aligned, 4'b0001);
    check("rst_mid.pre_lane", bus.cur_lane, 1);
    #2 px_reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge px_clk);
    bus.start = 1'b0;
    px_reset  = 1'b0;
    @(negedge px_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
